wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 Parameter REG_WIDTH, default 32, datapath and register width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk.
REQ-005 stall  in  1  hold the WB register contents this cycle.
REQ-006 flush  in  1  invalidate the WB register this cycle.
REQ-007 mem_valid  in  1  MEM stage holds a valid instruction.
REQ-008 mem_reg_wen  in  1  instruction writes rd.
REQ-009 mem_rd_addr  in  REG_ADDR_WIDTH  destination register.
REQ-010 mem_wb_sel  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-011 mem_alu_result  in  REG_WIDTH  ALU result; bits [1:0] are the load byte offset.
REQ-012 mem_pc_plus4  in  REG_WIDTH  link value.
REQ-013 mem_load_data  in  REG_WIDTH  raw aligned word from data memory.
REQ-014 mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-015 wr_en  out  1  register-file write enable.
REQ-016 addr_rd  out  REG_ADDR_WIDTH  register-file write address.
REQ-017 data_rd  out  REG_WIDTH  register-file write data.
REQ-018 wb_valid  out  1  WB register holds a valid instruction.
REQ-019 load_fault  out  1  WB instruction is a misaligned or illegal load.
REQ-020 retire_cnt  out  32  count of instructions retired through WB.

Function
REQ-021 Rising edge, priority: flush > stall > capture.
- flush: wb_valid<=0; other fields don't-care.
- stall without flush: all WB state holds.
- otherwise: capture wb_valid<=mem_valid plus all MEM fields.
REQ-022 data_rd is fully computed before capture and registered, giving 1-cycle latency from MEM inputs to the register-file write port with no combinational path from MEM inputs to outputs.
REQ-023 Select behaviour:
- sel 00: data = mem_alu_result.
- sel 10: data = mem_pc_plus4.
- sel 11: data = 0 and write suppressed.
REQ-024 Load (sel 01), off = mem_alu_result[1:0]:
- LB/LBU: select byte off, sign- or zero-extend to REG_WIDTH.
- LH/LHU: select halfword off[1], sign- or zero-extend.
- LW: whole word.
REQ-025 load_fault is registered as 1 and data_rd as 0 for a load with LH/LHU and off[0]=1, or LW and off!=0, or funct3 in {011,110,111}.
REQ-026 wr_en = wb_valid & reg_wen & ~load_fault & (wb_sel!=11) & (addr_rd!=0), driven combinationally from WB registers only.
REQ-027 load_fault and wr_en are 0 whenever wb_valid=0.
REQ-028 retire_cnt increments by 1 on each edge where a capture occurs with mem_valid=1 and no fault. The count is unaffected by stall, flush and invalid bubbles. It wraps from 0xFFFFFFFF to 0.
REQ-029 A stalled valid instruction keeps wr_en asserted every stalled cycle; rewriting the same value is permitted.
REQ-030 Flush and stall in the same cycle: flush wins, and retire_cnt does not increment.

Reset
REQ-031 While reset=1, all of the following are 0: wb_valid, wr_en, addr_rd, data_rd, load_fault and retire_cnt. All internal WB registers are also 0.
REQ-032 Reset assertion mid-operation drops wr_en in the same cycle without waiting for clk. The first capture occurs on the first rising edge after deassertion.

Verification
REQ-033 ALU writeback: mem_valid=1, reg_wen=1, rd=5, sel=00, alu=0x0000_1234 -> next cycle wr_en=1, addr_rd=5, data_rd=0x0000_1234, retire_cnt=1.
REQ-034 Load extension: load word 0x80FF_7F01.
- LB off=2 -> data_rd=0xFFFF_FFFF.
- LBU off=3 -> 0x0000_0080.
- LH off=0 -> 0x0000_7F01.
- LHU off=2 -> 0x0000_80FF.
REQ-035 Faults: LW off=1 and funct3=011 each -> load_fault=1, wr_en=0, data_rd=0, retire_cnt unchanged. A write to rd=0 with sel=10 -> wr_en=0.
REQ-036 Stall/flush:
- Valid instruction captured, then stall for 3 cycles -> outputs held for 3 cycles, retire_cnt +1 only once.
- flush and stall together -> wb_valid=0 next cycle.
REQ-037 Wrap and reset: preload 0xFFFF_FFFF retirements and retire one more -> retire_cnt=0. Assert reset between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register with load extraction, fault detection and retire counter.
module wb_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      mem_valid,
    input  logic                      mem_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [1:0]                mem_wb_sel,
    input  logic [REG_WIDTH-1:0]      mem_alu_result,
    input  logic [REG_WIDTH-1:0]      mem_pc_plus4,
    input  logic [REG_WIDTH-1:0]      mem_load_data,
    input  logic [2:0]                mem_funct3,
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] addr_rd,
    output logic [REG_WIDTH-1:0]      data_rd,
    output logic                      wb_valid,
    output logic                      load_fault,
    output logic [31:0]               retire_cnt
);
    logic [1:0]                off;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [REG_WIDTH-1:0]      load_val;
    logic                      bad_load;
    logic                      fault_d;
    logic [REG_WIDTH-1:0]      data_d;
    logic                      wb_valid_q;
    logic                      reg_wen_q;
    logic                      fault_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [1:0]                sel_q;
    logic [REG_WIDTH-1:0]      data_q;
    logic [31:0]               retire_q;

    assign off     = mem_alu_result[1:0];
    assign ld_byte = mem_load_data[{off, 3'b000} +: 8];
    assign ld_half = mem_load_data[{off[1], 4'b0000} +: 16];

    always_comb begin
        load_val = '0;
        bad_load = 1'b0;
        case (mem_funct3)
            3'b000: load_val = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100: load_val = {{(REG_WIDTH-8){1'b0}}, ld_byte};
            3'b001: begin
                load_val = {{(REG_WIDTH-16){ld_half[15]}}, ld_half};
                bad_load = off[0];
            end
            3'b101: begin
                load_val = {{(REG_WIDTH-16){1'b0}}, ld_half};
                bad_load = off[0];
            end
            3'b010: begin
                load_val = mem_load_data;
                bad_load = |off;
            end
            default: bad_load = 1'b1;
        endcase
    end

    // Faulting loads and the reserved select both register zero data.
    assign fault_d = (mem_wb_sel == 2'b01) & bad_load;
    assign data_d  = fault_d ? '0 :
                     mem_wb_sel == 2'b00 ? mem_alu_result :
                     mem_wb_sel == 2'b01 ? load_val :
                     mem_wb_sel == 2'b10 ? mem_pc_plus4 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            reg_wen_q  <= 1'b0;
            fault_q    <= 1'b0;
            rd_q       <= '0;
            sel_q      <= '0;
            data_q     <= '0;
            retire_q   <= '0;
        end else if (flush) begin
            wb_valid_q <= 1'b0;
        end else if (!stall) begin
            wb_valid_q <= mem_valid;
            reg_wen_q  <= mem_reg_wen;
            fault_q    <= fault_d;
            rd_q       <= mem_rd_addr;
            sel_q      <= mem_wb_sel;
            data_q     <= data_d;
            if (mem_valid && !fault_d)
                retire_q <= retire_q + 32'd1;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign addr_rd    = rd_q;
    assign data_rd    = data_q;
    assign retire_cnt = retire_q;
    assign load_fault = wb_valid_q & fault_q;
    assign wr_en      = wb_valid_q & reg_wen_q & ~fault_q & (sel_q != 2'b11) & (|rd_q);
endmodule
